// File: rtl/uart_pkg.sv
// Types shared by the UART transmit arbiter, uart_rx and uart_tx.
// Byte type, transmit arbiter FSM states and a pointer-width helper.
package uart_pkg;

    typedef logic [7:0] byte_t;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        START,
        WAIT_HI,
        WAIT_LO
    } tx_arb_state_e;

    function automatic int ptr_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/uart_tx_arbiter_rr.sv
// Round-robin search over a request vector.
// The pointer names the last lane served; the search starts just after it.
module rr_arbiter
    import uart_pkg::*;
#(
    parameter int N  = 4,
    parameter int PW = ptr_w(N)
) (
    input  logic          clk_i,
    input  logic          rst_n,
    input  logic [N-1:0]  req,
    input  logic          upd,
    input  logic [PW-1:0] upd_ptr,
    output logic [N-1:0]  gnt
);

    logic [PW-1:0] ptr;
    logic [PW-1:0] idx;
    logic          found;

    always_ff @(posedge clk_i) begin
        if (!rst_n) begin
            ptr <= PW'(N - 1);
        end else if (upd) begin
            ptr <= upd_ptr;
        end
    end

    always_comb begin
        gnt   = '0;
        idx   = '0;
        found = 1'b0;
        for (int k = 1; k <= N; k++) begin
            idx = PW'((int'(ptr) + k) % N);
            if (!found && req[idx]) begin
                gnt[idx] = 1'b1;
                found    = 1'b1;
            end
        end
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Shares one uart_tx serializer between NUM_REQ byte-stream lanes.
// Round-robin, packet-locked grants; one en pulse per byte.
module uart_tx_arbiter
    import uart_pkg::*;
#(
    parameter int NUM_REQ       = 4,
    parameter int BUSY_WAIT_MAX = 4
) (
    input  logic                 clk_i,
    input  logic                 rst_n,
    input  logic [NUM_REQ-1:0]   req_valid_i,
    input  logic [NUM_REQ*8-1:0] req_data_i,
    input  logic [NUM_REQ-1:0]   req_last_i,
    output logic [NUM_REQ-1:0]   req_ready_o,
    output logic                 uart_tx_en_o,
    output logic [7:0]           uart_tx_data_o,
    input  logic                 uart_tx_busy_i,
    output logic [NUM_REQ-1:0]   grant_o,
    output logic                 timeout_o
);

    localparam int PW = ptr_w(NUM_REQ);
    localparam int CW = $clog2(BUSY_WAIT_MAX + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(BUSY_WAIT_MAX - 1);

    tx_arb_state_e        state;
    logic [NUM_REQ-1:0]   grant_q;
    byte_t                data_q;
    logic                 last_q;
    logic [CW-1:0]        cnt;
    logic                 en_q;
    logic                 to_q;

    logic [NUM_REQ-1:0]   arb_gnt;
    logic [PW-1:0]        g_idx;
    logic                 sel_valid;
    byte_t                sel_data;
    logic                 sel_last;
    logic                 wait_expired;
    logic                 byte_done;
    logic                 rr_upd;

    always_comb begin
        g_idx     = '0;
        sel_valid = 1'b0;
        sel_data  = '0;
        sel_last  = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant_q[i]) begin
                g_idx     = PW'(i);
                sel_valid = req_valid_i[i];
                sel_data  = req_data_i[8*i +: 8];
                sel_last  = req_last_i[i];
            end
        end
    end

    // A missing busy edge is treated as a completed byte.
    assign wait_expired = (state == WAIT_HI) && !uart_tx_busy_i &&
                          (cnt == CNT_LAST);
    assign byte_done    = wait_expired ||
                          ((state == WAIT_LO) && !uart_tx_busy_i);
    assign rr_upd       = byte_done && last_q;

    rr_arbiter #(
        .N  (NUM_REQ),
        .PW (PW)
    ) u_rr (
        .clk_i   (clk_i),
        .rst_n   (rst_n),
        .req     (req_valid_i),
        .upd     (rr_upd),
        .upd_ptr (g_idx),
        .gnt     (arb_gnt)
    );

    always_ff @(posedge clk_i) begin
        if (!rst_n) begin
            state   <= IDLE;
            grant_q <= '0;
            data_q  <= '0;
            last_q  <= 1'b0;
            cnt     <= '0;
            en_q    <= 1'b0;
            to_q    <= 1'b0;
        end else begin
            en_q <= 1'b0;
            to_q <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (|req_valid_i && !uart_tx_busy_i) begin
                        grant_q <= arb_gnt;
                        state   <= LOAD;
                    end
                end
                LOAD: begin
                    if (sel_valid) begin
                        data_q <= sel_data;
                        last_q <= sel_last;
                        en_q   <= 1'b1;
                        state  <= START;
                    end
                end
                START: begin
                    cnt   <= '0;
                    state <= WAIT_HI;
                end
                WAIT_HI: begin
                    if (uart_tx_busy_i) begin
                        state <= WAIT_LO;
                    end else if (wait_expired) begin
                        to_q <= 1'b1;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                WAIT_LO: begin
                end
                default: begin
                    state <= IDLE;
                end
            endcase
            if (byte_done) begin
                if (last_q) begin
                    grant_q <= '0;
                    state   <= IDLE;
                end else begin
                    state <= LOAD;
                end
            end
        end
    end

    assign req_ready_o    = (state == LOAD) ? (grant_q & req_valid_i) : '0;
    assign uart_tx_en_o   = en_q;
    assign uart_tx_data_o = data_q;
    assign grant_o        = grant_q;
    assign timeout_o      = to_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter: lane drivers, uart_tx busy model,
// and a scoreboard of expected (lane, byte) pairs checked at each en.
module tb_uart_tx_arbiter;
    import uart_pkg::*;

    localparam int N        = 4;
    localparam int BUSY_LEN = 20;

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic [N-1:0]   req_valid = '0;
    logic [N*8-1:0] req_data = '0;
    logic [N-1:0]   req_last = '0;
    logic [N-1:0]   req_ready;
    logic           en;
    logic [7:0]     tx_data;
    logic           busy;
    logic [N-1:0]   grant;
    logic           timeout;

    uart_tx_arbiter #(
        .NUM_REQ       (N),
        .BUSY_WAIT_MAX (4)
    ) dut (
        .clk_i          (clk),
        .rst_n          (rst_n),
        .req_valid_i    (req_valid),
        .req_data_i     (req_data),
        .req_last_i     (req_last),
        .req_ready_o    (req_ready),
        .uart_tx_en_o   (en),
        .uart_tx_data_o (tx_data),
        .uart_tx_busy_i (busy),
        .grant_o        (grant),
        .timeout_o      (timeout)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [1:0] lane;
        logic [7:0] data;
    } exp_t;

    int   vectors = 0;
    int   miscompares = 0;
    exp_t sb[$];
    logic [8:0] lq [N][$];
    int   gap [N];
    int   gap_cfg [N];
    logic pend [N];
    int   rdy_cnt [N];
    int   to_cnt = 0;
    int   bcnt = 0;
    logic no_busy = 1'b0;
    logic ext_busy = 1'b0;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // uart_tx model: busy rises the cycle after en and lasts BUSY_LEN cycles
    assign busy = (bcnt > 0) || ext_busy;
    always @(posedge clk) begin
        if (en && !no_busy) bcnt <= BUSY_LEN;
        else if (bcnt > 0) bcnt <= bcnt - 1;
    end

    always @(negedge clk) begin
        for (int i = 0; i < N; i++) begin
            if (req_ready[i]) pend[i] = 1'b1;
        end
    end

    always @(posedge clk) begin
        #1;
        for (int i = 0; i < N; i++) begin
            if (gap[i] > 0 && !busy) gap[i]--;
            if (pend[i]) begin
                void'(lq[i].pop_front());
                pend[i] = 1'b0;
                gap[i]  = gap_cfg[i];
            end
            if (lq[i].size() > 0 && gap[i] == 0) begin
                req_valid[i]       = 1'b1;
                req_data[8*i +: 8] = lq[i][0][7:0];
                req_last[i]        = lq[i][0][8];
            end else begin
                req_valid[i]       = 1'b0;
                req_data[8*i +: 8] = 8'hEE;
                req_last[i]        = 1'b0;
            end
        end
    end

    always @(negedge clk) begin
        exp_t e;
        if (rst_n) begin
            if (req_ready != '0) begin
                chk("ready_not_granted", 32'(req_ready & ~grant), 32'(0));
                chk("ready_onehot", 32'($countones(req_ready)), 32'(1));
            end
            for (int i = 0; i < N; i++) begin
                if (req_ready[i]) rdy_cnt[i]++;
            end
            if (timeout) to_cnt++;
            if (en) begin
                if (sb.size() == 0) begin
                    chk("en_unexpected", 32'(1), 32'(0));
                end else begin
                    e = sb.pop_front();
                    chk("en_data", 32'(tx_data), 32'(e.data));
                    chk("en_grant", 32'(grant), 32'(N'(1) << e.lane));
                end
            end
        end
    end

    task automatic send(input int lane, input logic [7:0] d,
                        input logic last);
        exp_t e;
        e.lane = 2'(lane);
        e.data = d;
        lq[lane].push_back({last, d});
        sb.push_back(e);
    endtask

    function automatic bit lanes_pending();
        for (int i = 0; i < N; i++) begin
            if (lq[i].size() != 0) return 1'b1;
        end
        return 1'b0;
    endfunction

    task automatic wait_done(input string tag, input int maxc);
        int k = 0;
        while ((sb.size() != 0 || grant != '0 || busy || lanes_pending())
               && k < maxc) begin
            @(negedge clk);
            k++;
        end
        chk({tag, "_drain"}, 32'(k >= maxc), 32'(0));
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int k;
        for (int i = 0; i < N; i++) begin
            gap[i] = 0;
            gap_cfg[i] = 0;
            pend[i] = 1'b0;
            rdy_cnt[i] = 0;
        end
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        chk("rst_grant", 32'(grant), 32'(0));
        chk("rst_en", 32'(en), 32'(0));
        chk("rst_timeout", 32'(timeout), 32'(0));
        chk("rst_data", 32'(tx_data), 32'(0));
        chk("rst_ready", 32'(req_ready), 32'(0));

        // single byte and latency
        send(0, 8'hA5, 1'b1);
        k = 0;
        while (!req_ready[0] && k < 10) begin
            @(negedge clk);
            k++;
        end
        chk("t1_ready_lat", 32'(k), 32'(2));
        @(negedge clk);
        chk("t1_en_lat", 32'(en), 32'(1));
        k = 0;
        while (!busy && k < 10) begin
            @(negedge clk);
            k++;
        end
        k = 0;
        while (busy && k < 40) begin
            @(negedge clk);
            k++;
        end
        chk("t1_busy_fall", 32'(k >= 40), 32'(0));
        chk("t1_grant_held", 32'(grant), 32'(4'b0001));
        @(negedge clk);
        chk("t1_grant_clear", 32'(grant), 32'(0));
        chk("t1_ready_cnt", 32'(rdy_cnt[0]), 32'(1));
        chk("t1_no_timeout", 32'(to_cnt), 32'(0));

        // contention from reset pointer, then wrap
        do_reset();
        send(0, 8'h10, 1'b1);
        send(1, 8'h21, 1'b1);
        send(2, 8'h32, 1'b1);
        send(3, 8'h43, 1'b1);
        wait_done("t2a", 400);
        @(negedge clk);
        send(0, 8'h54, 1'b1);
        send(2, 8'h65, 1'b1);
        wait_done("t2b", 200);
        chk("t2_ready0", 32'(rdy_cnt[0]), 32'(3));
        chk("t2_ready2", 32'(rdy_cnt[2]), 32'(2));

        // packet lock with valid gaps on the owner
        gap_cfg[1] = 5;
        @(negedge clk);
        send(1, 8'h11, 1'b0);
        send(1, 8'h22, 1'b0);
        send(1, 8'h33, 1'b1);
        k = 0;
        while (grant != 4'b0010 && k < 10) begin
            @(negedge clk);
            k++;
        end
        chk("t3_grant1", 32'(grant), 32'(4'b0010));
        send(0, 8'h44, 1'b1);
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            chk("t3_lock", 32'(grant), 32'(4'b0010));
        end
        wait_done("t3", 400);
        gap_cfg[1] = 0;
        chk("t3_ready1", 32'(rdy_cnt[1]), 32'(4));
        chk("t3_ready0", 32'(rdy_cnt[0]), 32'(4));

        // busy never rises
        @(negedge clk);
        no_busy = 1'b1;
        send(2, 8'h5A, 1'b1);
        k = 0;
        while (!en && k < 20) begin
            @(negedge clk);
            k++;
        end
        chk("t4_en_seen", 32'(en), 32'(1));
        k = 0;
        while (!timeout && k < 10) begin
            @(negedge clk);
            k++;
        end
        chk("t4_timeout_lat", 32'(k), 32'(5));
        chk("t4_grant_clear", 32'(grant), 32'(0));
        no_busy = 1'b0;
        @(negedge clk);
        chk("t4_timeout_pulse", 32'(timeout), 32'(0));
        send(3, 8'hC3, 1'b1);
        wait_done("t4", 200);
        chk("t4_timeout_cnt", 32'(to_cnt), 32'(1));

        // reset while waiting for busy to fall
        @(negedge clk);
        send(1, 8'h77, 1'b1);
        k = 0;
        while (!(busy && grant != '0) && k < 20) begin
            @(negedge clk);
            k++;
        end
        repeat (3) @(negedge clk);
        chk("t5_in_wait_lo", 32'(grant), 32'(4'b0010));
        rst_n = 1'b0;
        @(negedge clk);
        chk("t5_grant", 32'(grant), 32'(0));
        chk("t5_en", 32'(en), 32'(0));
        chk("t5_timeout", 32'(timeout), 32'(0));
        chk("t5_data", 32'(tx_data), 32'(0));
        chk("t5_ready", 32'(req_ready), 32'(0));
        rst_n = 1'b1;
        send(0, 8'h81, 1'b1);
        send(3, 8'h93, 1'b1);
        wait_done("t5", 400);

        // external busy holds off the grant
        @(negedge clk);
        ext_busy = 1'b1;
        send(2, 8'hE7, 1'b1);
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            chk("t6_no_grant", 32'(grant), 32'(0));
            chk("t6_no_ready", 32'(req_ready), 32'(0));
        end
        ext_busy = 1'b0;
        k = 0;
        while (!req_ready[2] && k < 10) begin
            @(negedge clk);
            k++;
        end
        chk("t6_ready_lat", 32'(k), 32'(1));
        wait_done("t6", 200);

        chk("sb_empty", 32'(sb.size()), 32'(0));
        chk("final_timeouts", 32'(to_cnt), 32'(1));
        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

endmodule
